// File: rtl/spi_sensor_master.sv
// SPI mode-0 read-only master: one DATA_WIDTH-bit sample per accepted request,
// shifted in MSB-first and presented on dato with a one-cycle dato_valid strobe.
module spi_sensor_master #(
    parameter int CLK_DIV    = 5,
    parameter int DATA_WIDTH = 16,
    parameter int CS_SETUP   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  send_spi,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  cs_n,
    output logic [DATA_WIDTH-1:0] dato,
    output logic                  dato_valid,
    output logic                  busy
);

    localparam int CntW = (CS_SETUP > 1) ? $clog2(CS_SETUP) : 1;
    localparam int DivW = $clog2(CLK_DIV);
    localparam int BitW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_t;

    state_t                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DivW-1:0]       div_q, div_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] dato_q, dato_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_n_q, cs_n_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  miso_s1_q, miso_s2_q;

    // State and output registers, plus the 2-FF miso synchronizer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            dato_q    <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            dato_q    <= dato_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            miso_s1_q <= miso;
            miso_s2_q <= miso_s1_q;
        end
    end

    // Next-state logic: CS setup, SCLK generation/sampling, CS hold, completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        dato_d  = dato_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        valid_d = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            StIdle: begin
                if (send_spi) begin
                    state_d = StSetup;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    shift_d = '0;
                    bit_d   = '0;
                    cnt_d   = '0;
                end
            end
            StSetup: begin
                if (cnt_q == CntW'(CS_SETUP - 1)) begin
                    state_d = StShift;
                    div_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StShift: begin
                if (div_q == DivW'(CLK_DIV - 1)) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        // Rising edge: sample the synchronized data bit.
                        shift_d = {shift_q[DATA_WIDTH-2:0], miso_s2_q};
                        bit_d   = bit_q + BitW'(1);
                    end else if (bit_q == BitW'(DATA_WIDTH)) begin
                        // Falling edge after the last rise: sclk is now parked low.
                        state_d = StHold;
                        cnt_d   = '0;
                    end
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            StHold: begin
                if (cnt_q == CntW'(CS_SETUP - 1)) begin
                    state_d = StIdle;
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    dato_d  = shift_q;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign sclk       = sclk_q;
    assign cs_n       = cs_n_q;
    assign dato       = dato_q;
    assign dato_valid = valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_spi_sensor_master.sv
// Bench for spi_sensor_master: default instance (a) and a small-parameter instance (b),
// each driven by a behavioural sensor that shifts queued words out MSB-first on sclk falls.
module tb_spi_sensor_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        send_a = 1'b1;
    logic        send_b = 1'b1;
    logic [1:0]  miso_v = 2'b00;
    logic        sclk_a, cs_a, valid_a, busy_a;
    logic        sclk_b, cs_b, valid_b, busy_b;
    logic [15:0] dato_a;
    logic [11:0] dato_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic rst_seen = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    spi_sensor_master dut_a (
        .clk(clk), .rst(rst), .send_spi(send_a), .miso(miso_v[0]),
        .sclk(sclk_a), .cs_n(cs_a), .dato(dato_a), .dato_valid(valid_a), .busy(busy_a)
    );

    spi_sensor_master #(.CLK_DIV(4), .DATA_WIDTH(12), .CS_SETUP(1)) dut_b (
        .clk(clk), .rst(rst), .send_spi(send_b), .miso(miso_v[1]),
        .sclk(sclk_b), .cs_n(cs_b), .dato(dato_b), .dato_valid(valid_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Sensor words per instance, consumed one per cs_n fall.
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];

    logic [15:0] cur_w[2];
    int          bidx[2];
    int          rises[2];
    int          vcount[2];
    int          last_v[2];
    int          prev_v[2];
    logic [1:0]  prev_cs = 2'b11;
    logic [1:0]  prev_sc = 2'b00;

    initial begin
        for (int d = 0; d < 2; d++) begin
            cur_w[d] = '0; bidx[d] = -1; rises[d] = 0;
            vcount[d] = 0; last_v[d] = 0; prev_v[d] = 0;
        end
    end

    // Sensor model and protocol monitor, evaluated away from the active edge.
    always @(negedge clk) begin
        logic [1:0] cs_v, sc_v, vl_v;
        cs_v = {cs_b, cs_a};
        sc_v = {sclk_b, sclk_a};
        vl_v = {valid_b, valid_a};
        for (int d = 0; d < 2; d++) begin
            int dw;
            dw = (d == 0) ? 16 : 12;
            if (!rst_seen) begin
                if (sc_v[d] !== prev_sc[d]) chk("sclk_toggle_with_cs_high", 32'(cs_v[d] | prev_cs[d]), 0);
                if (cs_v[d] !== prev_cs[d]) chk("cs_change_with_sclk_high", 32'(sc_v[d] | prev_sc[d]), 0);
            end
            if (sc_v[d] && !prev_sc[d]) rises[d]++;
            if (!cs_v[d] && prev_cs[d]) begin
                rises[d] = 0;
                if (d == 0) cur_w[d] = (q_a.size() > 0) ? q_a.pop_front() : 16'h0;
                else        cur_w[d] = (q_b.size() > 0) ? q_b.pop_front() : 16'h0;
                bidx[d]   = dw - 1;
                miso_v[d] = cur_w[d][bidx[d]];
            end else if (!cs_v[d] && !sc_v[d] && prev_sc[d]) begin
                bidx[d]--;
                miso_v[d] = (bidx[d] >= 0) ? cur_w[d][bidx[d]] : 1'b0;
            end
            if (vl_v[d]) begin
                vcount[d]++;
                prev_v[d] = last_v[d];
                last_v[d] = cyc;
                chk("rises_per_txn", rises[d], dw);
            end
        end
        prev_cs = cs_v;
        prev_sc = sc_v;
    end

    task automatic goto_edge(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample_at(input int e);
        goto_edge(e);
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_a(input int e);
        goto_edge(e - 1);
        send_a = 1'b1;
        goto_edge(e);
        send_a = 1'b0;
    endtask

    initial begin
        int k, l, k2, k3, k4, kb, e;
        logic [15:0] w;

        // Reset with a request pending: nothing may start.
        for (int i = 1; i <= 3; i++) begin
            sample_at(i);
            chk("rst_cs_n", cs_a, 1);
            chk("rst_sclk", sclk_a, 0);
            chk("rst_busy", busy_a, 0);
            chk("rst_dato", dato_a, 0);
            chk("rst_valid", valid_a, 0);
            chk("rst_b_cs_n", cs_b, 1);
        end
        goto_edge(3);
        rst = 1'b0; send_a = 1'b0; send_b = 1'b0;

        // Single read with ignored requests mid-transaction and at the completion edge.
        q_a.push_back(16'hA5C3);
        q_a.push_back(16'h0001);
        k = 10;
        l = k + 164;
        pulse_a(k);
        sample_at(k);
        chk("start_cs_n", cs_a, 0);
        chk("start_busy", busy_a, 1);
        sample_at(k + 6);
        chk("pre_first_rise", sclk_a, 0);
        sample_at(k + 7);
        chk("first_rise", sclk_a, 1);
        pulse_a(k + 50);
        sample_at(l - 1);
        chk("pre_done_valid", valid_a, 0);
        chk("pre_done_busy", busy_a, 1);
        send_a = 1'b1;
        sample_at(l);
        chk("done_valid", valid_a, 1);
        chk("done_dato", dato_a, 16'hA5C3);
        chk("done_busy", busy_a, 0);
        chk("done_cs_n", cs_a, 1);
        goto_edge(l + 1);
        send_a = 1'b0;
        sample_at(l + 1);
        chk("b2b_cs_n", cs_a, 0);
        chk("b2b_valid", valid_a, 0);
        k2 = l + 1;
        sample_at(k2 + 164);
        chk("second_valid", valid_a, 1);
        chk("second_dato", dato_a, 16'h0001);
        chk("valid_count_1", vcount[0], 2);

        // Reset mid-transaction: abort, no strobe, registers back to reset values.
        q_a.push_back(16'h1234);
        k3 = k2 + 170;
        pulse_a(k3);
        goto_edge(k3 + 79);
        rst = 1'b1;
        goto_edge(k3 + 80);
        rst = 1'b0;
        sample_at(k3 + 80);
        chk("abort_cs_n", cs_a, 1);
        chk("abort_sclk", sclk_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_dato", dato_a, 0);
        sample_at(k3 + 200);
        chk("abort_no_valid", vcount[0], 2);

        // Held request: back-to-back reads of the data extremes.
        q_a.push_back(16'hFFFF);
        q_a.push_back(16'h0000);
        k4 = k3 + 210;
        goto_edge(k4 - 1);
        send_a = 1'b1;
        sample_at(k4 + 164);
        chk("held1_valid", valid_a, 1);
        chk("held1_dato", dato_a, 16'hFFFF);
        sample_at(k4 + 165);
        chk("held_retrigger_cs_n", cs_a, 0);
        chk("held_valid_low", valid_a, 0);
        goto_edge(k4 + 170);
        send_a = 1'b0;
        sample_at(k4 + 329);
        chk("held2_valid", valid_a, 1);
        chk("held2_dato", dato_a, 16'h0000);
        chk("held_spacing", last_v[0] - prev_v[0], 165);
        sample_at(k4 + 330);
        chk("held_end_busy", busy_a, 0);
        chk("held_end_cs_n", cs_a, 1);

        // Small-parameter instance.
        q_b.push_back(16'h09F3);
        kb = k4 + 340;
        goto_edge(kb - 1);
        send_b = 1'b1;
        goto_edge(kb);
        send_b = 1'b0;
        sample_at(kb + 4);
        chk("b_pre_first_rise", sclk_b, 0);
        sample_at(kb + 5);
        chk("b_first_rise", sclk_b, 1);
        sample_at(kb + 97);
        chk("b_pre_valid", valid_b, 0);
        sample_at(kb + 98);
        chk("b_valid", valid_b, 1);
        chk("b_dato", dato_b, 12'h9F3);
        sample_at(kb + 99);
        chk("b_valid_pulse", valid_b, 0);

        // Random words, random gaps, random stray requests while busy.
        k = kb + 110;
        for (int n = 0; n < 8; n++) begin
            w = 16'($urandom);
            q_a.push_back(w);
            pulse_a(k);
            e = k + $urandom_range(2, 160);
            pulse_a(e);
            sample_at(k + 163);
            chk("rnd_pre_valid", valid_a, 0);
            sample_at(k + 164);
            chk("rnd_valid", valid_a, 1);
            chk("rnd_dato", dato_a, w);
            k = k + 165 + $urandom_range(0, 10);
        end
        sample_at(k + 5);
        chk("total_valid_a", vcount[0], 12);
        chk("total_valid_b", vcount[1], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
